fp_div_iter: RTL and testbench

//  Parametrised iterative IEEE-style FP divider; successor to the fixed single-precision divider.

---
 rtl/fp_div_pkg.sv | 37 +++
 rtl/fp_div_special.sv | 58 +++++
 rtl/fp_div_iter.sv | 143 ++++++++++++++
 tb/tb_fp_div_iter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared constants, state encodings and operand class codes for the iterative FP divider.
// Width helpers let each instance derive its own sizes from EXP_W/MAN_W/GUARD.
package fp_div_pkg;

   localparam int DEF_EXP_W = 8;
   localparam int DEF_MAN_W = 23;
   localparam int DEF_GUARD = 2;

   function automatic int calc_sw(input int man_w);
      return man_w + 1;
   endfunction

   function automatic int calc_qw(input int man_w, input int guard);
      return man_w + guard + 2;
   endfunction

   function automatic int calc_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   localparam int SW   = calc_sw(DEF_MAN_W);
   localparam int QW   = calc_qw(DEF_MAN_W, DEF_GUARD);
   localparam int BIAS = calc_bias(DEF_EXP_W);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DIV  = 2'd1;
   localparam logic [1:0] ST_NORM = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } fp_class_e;

endpackage

// File: rtl/fp_div_special.sv
// Operand classifier and special-result generator for one dividend/divisor pair.
// Denormals classify as zero; special is high when no mantissa divide is needed.
module fp_div_special
   import fp_div_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int GUARD = 2
) (
   input  logic [EXP_W+MAN_W-1:0] a_mag,
   input  logic [EXP_W+MAN_W-1:0] b_mag,
   output logic                   special,
   output logic [EXP_W+1:0]       res_exp,
   output logic [MAN_W+GUARD+1:0] res_man,
   output logic                   div_zero,
   output logic                   invalid
);

   localparam int QMW = MAN_W + GUARD + 2;

   function automatic fp_class_e classify(input logic [EXP_W+MAN_W-1:0] x);
      if (x[MAN_W +: EXP_W] == '0)
         return CLS_ZERO;
      if (x[MAN_W +: EXP_W] == '1)
         return (x[MAN_W-1:0] == '0) ? CLS_INF : CLS_NAN;
      return CLS_NORM;
   endfunction

   fp_class_e cls_a;
   fp_class_e cls_b;

   assign cls_a = classify(a_mag);
   assign cls_b = classify(b_mag);

   // NOTE: every output gets a default first so no path through the decode infers a latch.
   always_comb begin
      special  = 1'b1;
      res_exp  = '0;
      res_man  = '0;
      div_zero = 1'b0;
      invalid  = 1'b0;
      if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
          (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
          (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
         invalid = 1'b1;
         res_exp = {2'b00, {EXP_W{1'b1}}};
         res_man = {2'b11, {(QMW-2){1'b0}}};
      end else if (cls_a == CLS_INF || cls_b == CLS_ZERO) begin
         res_exp  = {2'b00, {EXP_W{1'b1}}};
         div_zero = (cls_b == CLS_ZERO);
      end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
         res_exp = '0;
      end else begin
         special = 1'b0;
      end
   end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative restoring radix-2 FP divider: one quotient bit per cycle, then a single
// normalisation step producing {hidden, frac, guard, sticky}; rounding happens downstream.
module fp_div_iter
   import fp_div_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int GUARD = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stall,
   input  logic [EXP_W+MAN_W:0]   a_in,
   input  logic [EXP_W+MAN_W:0]   b_in,
   output logic                   busy,
   output logic                   done,
   output logic                   q_sign,
   output logic [EXP_W+1:0]       q_exp,
   output logic [MAN_W+GUARD+1:0] q_man,
   output logic                   div_zero,
   output logic                   invalid
);

   localparam int SIG_W    = calc_sw(MAN_W);
   localparam int Q_W      = calc_qw(MAN_W, GUARD);
   localparam int EXP_BIAS = calc_bias(EXP_W);
   localparam int CW       = $clog2(Q_W + 1);
   localparam int XW       = EXP_W + 2;

   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic [SIG_W:0]   rem;
   logic [Q_W-1:0]   quo;
   logic [SIG_W-1:0] sig_b;
   logic [EXP_W-1:0] exp_a;
   logic [EXP_W-1:0] exp_b;

   logic                   sp_hit;
   logic [XW-1:0]          sp_exp;
   logic [Q_W-1:0]         sp_man;
   logic                   sp_dz;
   logic                   sp_inv;

   logic                   rem_ge;
   logic [SIG_W-1:0]       rem_diff;
   logic [SIG_W:0]         rem_next;
   logic [XW-1:0]          exp_raw;
   logic [XW-1:0]          norm_exp;
   logic [Q_W-1:0]         norm_man;
   logic                   rem_nz;

   fp_div_special #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W),
      .GUARD (GUARD)
   ) u_special (
      .a_mag    (a_in[EXP_W+MAN_W-1:0]),
      .b_mag    (b_in[EXP_W+MAN_W-1:0]),
      .special  (sp_hit),
      .res_exp  (sp_exp),
      .res_man  (sp_man),
      .div_zero (sp_dz),
      .invalid  (sp_inv)
   );

   // The partial remainder always stays below 2*sig_b, so the difference fits in SIG_W bits.
   assign rem_ge   = (rem >= {1'b0, sig_b});
   assign rem_diff = rem[SIG_W-1:0] - sig_b;
   assign rem_next = rem_ge ? {rem_diff, 1'b0} : {rem[SIG_W-1:0], 1'b0};
   assign rem_nz   = |rem;

   // Quotient lies in (0.5, 2): the top bit decides whether one extra shift is needed.
   assign exp_raw  = {2'b00, exp_a} - {2'b00, exp_b} + XW'(EXP_BIAS);
   assign norm_exp = quo[Q_W-1] ? exp_raw : exp_raw - XW'(1);
   assign norm_man = quo[Q_W-1] ? {quo[Q_W-1:1], quo[0] | rem_nz}
                                : {quo[Q_W-2:0], rem_nz};

   assign busy = (state == ST_DIV) || (state == ST_NORM);

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= '0;
         rem      <= '0;
         quo      <= '0;
         sig_b    <= '0;
         exp_a    <= '0;
         exp_b    <= '0;
         done     <= 1'b0;
         q_sign   <= 1'b0;
         q_exp    <= '0;
         q_man    <= '0;
         div_zero <= 1'b0;
         invalid  <= 1'b0;
      end else if (!stall) begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  q_sign <= a_in[EXP_W+MAN_W] ^ b_in[EXP_W+MAN_W];
                  if (sp_hit) begin
                     q_exp    <= sp_exp;
                     q_man    <= sp_man;
                     div_zero <= sp_dz;
                     invalid  <= sp_inv;
                     done     <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     exp_a <= a_in[MAN_W +: EXP_W];
                     exp_b <= b_in[MAN_W +: EXP_W];
                     sig_b <= {1'b1, b_in[MAN_W-1:0]};
                     rem   <= {2'b01, a_in[MAN_W-1:0]};
                     quo   <= '0;
                     count <= '0;
                     state <= ST_DIV;
                  end
               end
            end
            ST_DIV: begin
               rem   <= rem_next;
               quo   <= {quo[Q_W-2:0], rem_ge};
               count <= count + CW'(1);
               if (count == CW'(Q_W - 1))
                  state <= ST_NORM;
            end
            ST_NORM: begin
               q_exp    <= norm_exp;
               q_man    <= norm_man;
               div_zero <= 1'b0;
               invalid  <= 1'b0;
               done     <= 1'b1;
               state    <= ST_DONE;
            end
            default: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter: single-precision and double-precision instances,
// directed corner cases plus random operands checked against an arithmetic reference model.
module tb_fp_div_iter;

   localparam int G = 2;

   typedef struct {
      logic        sign;
      logic [15:0] exp;
      logic [63:0] man;
      logic        dz;
      logic        inv;
      int          lat;     // clock edges from the accepting edge to the edge raising done
      int          t0;
      bit          chk_real;
      real         ratio;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        start_s = 1'b0, stall_s = 1'b0;
   logic [31:0] a_s = '0, b_s = '0;
   logic        busy_s, done_s, sign_s, dz_s, inv_s;
   logic [9:0]  qe_s;
   logic [26:0] qm_s;

   logic        start_d = 1'b0, stall_d = 1'b0;
   logic [63:0] a_d = '0, b_d = '0;
   logic        busy_d, done_d, sign_d, dz_d, inv_d;
   logic [12:0] qe_d;
   logic [55:0] qm_d;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t q_sp[$];
   exp_t q_dp[$];
   exp_t mon_s, mon_d;
   logic done_s_q = 1'b0, done_d_q = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fp_div_iter #(.EXP_W(8), .MAN_W(23), .GUARD(G)) u_sp (
      .clk(clk), .rst(rst), .start(start_s), .stall(stall_s), .a_in(a_s), .b_in(b_s),
      .busy(busy_s), .done(done_s), .q_sign(sign_s), .q_exp(qe_s), .q_man(qm_s),
      .div_zero(dz_s), .invalid(inv_s));

   fp_div_iter #(.EXP_W(11), .MAN_W(52), .GUARD(G)) u_dp (
      .clk(clk), .rst(rst), .start(start_d), .stall(stall_d), .a_in(a_d), .b_in(b_d),
      .busy(busy_d), .done(done_d), .q_sign(sign_d), .q_exp(qe_d), .q_man(qm_d),
      .div_zero(dz_d), .invalid(inv_d));

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic exp_t mk(input logic sgn, input logic [15:0] ex, input logic [63:0] man,
                               input logic dz, input logic inv, input int lat);
      exp_t e;
      e.sign = sgn; e.exp = ex; e.man = man; e.dz = dz; e.inv = inv;
      e.lat = lat; e.t0 = 0; e.chk_real = 1'b0; e.ratio = 0.0;
      return e;
   endfunction

   // 0 zero/denormal, 1 normal, 2 infinity, 3 NaN
   function automatic int cls(input longint unsigned ex, input longint unsigned fr,
                              input longint unsigned emask);
      if (ex == 0) return 0;
      if (ex == emask) return (fr == 0) ? 2 : 3;
      return 1;
   endfunction

   function automatic real to_real(input logic [63:0] x, input int ew, input int mw);
      longint unsigned ex = (x >> mw) & ((64'd1 << ew) - 1);
      longint unsigned fr = x & ((64'd1 << mw) - 1);
      int  bias = (1 << (ew - 1)) - 1;
      real r = (1.0 + real'(fr) / (2.0 ** real'(mw))) * (2.0 ** real'(int'(ex) - bias));
      return x[ew+mw] ? -r : r;
   endfunction

   function automatic real dut_val(input logic sgn, input logic [63:0] ex, input logic [63:0] man,
                                   input int ew, input int mw);
      int  x = int'(ex);
      int  bias = (1 << (ew - 1)) - 1;
      real v;
      if (ex[ew+1]) x -= (1 << (ew + 2));
      v = real'(man >> 1) * (2.0 ** real'(x - bias - (mw + G)));
      return sgn ? -v : v;
   endfunction

   // Reference: exact quotient floor(sig_a * 2^(QW-1) / sig_b) by integer division.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int ew, input int mw);
      exp_t e;
      longint unsigned emask = (64'd1 << ew) - 1;
      longint unsigned fmask = (64'd1 << mw) - 1;
      longint unsigned ea = (a >> mw) & emask, eb = (b >> mw) & emask;
      longint unsigned fa = a & fmask, fb = b & fmask;
      int ca = cls(ea, fa, emask), cb = cls(eb, fb, emask);
      int qw = mw + G + 2;
      int bias = (1 << (ew - 1)) - 1;
      logic [127:0] num, den, qq, rr, mant;
      logic st;
      int ee;
      e = mk(a[ew+mw] ^ b[ew+mw], 16'd0, 64'd0, 1'b0, 1'b0, 0);
      if (ca == 3 || cb == 3 || (ca == 0 && cb == 0) || (ca == 2 && cb == 2)) begin
         e.inv = 1'b1; e.exp = 16'(emask); e.man = 64'd3 << (qw - 2);
      end else if (ca == 2 || cb == 0) begin
         e.exp = 16'(emask); e.dz = (cb == 0);
      end else if (ca == 0 || cb == 2) begin
         e.exp = 16'd0;
      end else begin
         num = 128'((64'd1 << mw) | fa) << (qw - 1);
         den = 128'((64'd1 << mw) | fb);
         qq = num / den;
         rr = num % den;
         if ((qq >> (qw - 1)) != 0) begin
            mant = qq >> 1; st = qq[0] | (rr != 0); ee = int'(ea) - int'(eb) + bias;
         end else begin
            mant = qq; st = (rr != 0); ee = int'(ea) - int'(eb) + bias - 1;
         end
         e.man = 64'((mant << 1) | 128'(st));
         e.exp = 16'(ee) & 16'((32'd1 << (ew + 2)) - 1);
         e.lat = qw + 1;
         e.chk_real = 1'b1;
         e.ratio = to_real(a, ew, mw) / to_real(b, ew, mw);
      end
      return e;
   endfunction

   function automatic logic [63:0] rand_op(input int ew, input int mw, input int lo, input int hi);
      longint unsigned emask = (64'd1 << ew) - 1;
      longint unsigned ex;
      longint unsigned fr = {$urandom, $urandom} & ((64'd1 << mw) - 1);
      int k = $urandom_range(11, 0);
      case (k)
         0: ex = 0;
         1: begin ex = 0; fr = 0; end
         2: begin ex = emask; fr = 0; end
         3: ex = emask;
         default: ex = longint'($urandom_range(hi, lo));
      endcase
      return (64'($urandom_range(1, 0)) << (ew + mw)) | (ex << mw) | fr;
   endfunction

   task automatic compare(input string tag, input exp_t e, input logic sgn, input logic [63:0] ex,
                          input logic [63:0] man, input logic dz, input logic inv,
                          input int ew, input int mw);
      real v, err, tol;
      check({tag, "_latency"}, 64'(cyc - e.t0 - 1), 64'(e.lat));
      check({tag, "_sign"}, 64'(sgn), 64'(e.sign));
      check({tag, "_exp"}, ex, 64'(e.exp));
      check({tag, "_man"}, man, e.man);
      check({tag, "_div_zero"}, 64'(dz), 64'(e.dz));
      check({tag, "_invalid"}, 64'(inv), 64'(e.inv));
      if (e.chk_real) begin
         v   = dut_val(sgn, ex, man, ew, mw);
         err = v - e.ratio;
         if (err < 0.0) err = -err;
         tol = (e.ratio < 0.0 ? -e.ratio : e.ratio) * ((2.0 ** real'(-(mw + G))) + (2.0 ** -50.0));
         check({tag, "_real_within_tol"}, 64'(err <= tol), 64'd1);
      end
   endtask

   always @(negedge clk) begin
      if (done_s && !done_s_q) begin
         if (q_sp.size() == 0) check("sp_unexpected_done", 64'd1, 64'd0);
         else begin
            mon_s = q_sp.pop_front();
            compare("sp", mon_s, sign_s, 64'(qe_s), 64'(qm_s), dz_s, inv_s, 8, 23);
         end
      end
      done_s_q <= done_s;
   end

   always @(negedge clk) begin
      if (done_d && !done_d_q) begin
         if (q_dp.size() == 0) check("dp_unexpected_done", 64'd1, 64'd0);
         else begin
            mon_d = q_dp.pop_front();
            compare("dp", mon_d, sign_d, 64'(qe_d), 64'(qm_d), dz_d, inv_d, 11, 52);
         end
      end
      done_d_q <= done_d;
   end

   task automatic issue(input bit dp, input logic [63:0] a, input logic [63:0] b, input exp_t e);
      @(negedge clk);
      e.t0 = cyc;
      if (dp) begin
         a_d = a; b_d = b; start_d = 1'b1; q_dp.push_back(e);
      end else begin
         a_s = a[31:0]; b_s = b[31:0]; start_s = 1'b1; q_sp.push_back(e);
      end
      @(negedge clk);
      start_s = 1'b0;
      start_d = 1'b0;
   endtask

   task automatic drain(input bit dp);
      int n = 0;
      while (((dp ? q_dp.size() : q_sp.size()) != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         check(dp ? "dp_done_timeout" : "sp_done_timeout", 64'd1, 64'd0);
         if (dp) q_dp.delete(); else q_sp.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy_s), 64'd0);
      check("rst_done", 64'(done_s), 64'd0);
      check("rst_q_exp", 64'(qe_s), 64'd0);
      check("rst_q_man", 64'(qm_s), 64'd0);
      check("rst_flags", 64'({sign_s, dz_s, inv_s}), 64'd0);
      check("rst_dp_done", 64'(done_d), 64'd0);
      rst = 1'b0;

      // 6/2, 1/3, -1/0, 0/0 with hand-derived results
      issue(0, 64'h40C00000, 64'h40000000, mk(1'b0, 16'd128, 64'h6000000, 1'b0, 1'b0, 28));
      drain(0);
      issue(0, 64'h3F800000, 64'h40400000, mk(1'b0, 16'd125, 64'h5555555, 1'b0, 1'b0, 28));
      drain(0);
      issue(0, 64'hBF800000, 64'h00000000, mk(1'b1, 16'd255, 64'h0, 1'b1, 1'b0, 0));
      drain(0);
      issue(0, 64'h00000000, 64'h00000000, mk(1'b0, 16'd255, 64'h6000000, 1'b0, 1'b1, 0));
      drain(0);

      // 7/2 with a 5-cycle stall in the middle of the divide
      issue(0, 64'h40E00000, 64'h40000000, mk(1'b0, 16'd128, 64'h7000000, 1'b0, 1'b0, 33));
      repeat (9) @(negedge clk);
      stall_s = 1'b1;
      repeat (5) @(negedge clk);
      check("stall_busy_held", 64'(busy_s), 64'd1);
      check("stall_no_done", 64'(done_s), 64'd0);
      stall_s = 1'b0;
      drain(0);

      // reset in the middle of a divide discards the result
      @(negedge clk);
      a_s = 32'h40C00000; b_s = 32'h40000000; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_rst_busy", 64'(busy_s), 64'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 64'(busy_s), 64'd0);
      check("mid_rst_done", 64'(done_s), 64'd0);
      check("mid_rst_q_exp", 64'(qe_s), 64'd0);
      check("mid_rst_q_man", 64'(qm_s), 64'd0);
      check("mid_rst_flags", 64'({sign_s, dz_s, inv_s}), 64'd0);
      @(negedge clk);
      check("mid_rst_done_next", 64'(done_s), 64'd0);
      rst = 1'b0;
      issue(0, 64'h40C00000, 64'h40000000, mk(1'b0, 16'd128, 64'h6000000, 1'b0, 1'b0, 28));
      drain(0);

      // start while busy and start coincident with done are both ignored
      issue(0, 64'h40C00000, 64'h40000000, mk(1'b0, 16'd128, 64'h6000000, 1'b0, 1'b0, 28));
      repeat (5) @(negedge clk);
      a_s = 32'h3F800000; b_s = 32'h40400000; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      n = 0;
      while (!done_s && n < 100) begin
         @(negedge clk);
         n++;
      end
      a_s = 32'h40E00000; b_s = 32'h40000000; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      drain(0);
      check("start_in_done_ignored", 64'(busy_s), 64'd0);

      for (int i = 0; i < 40; i++) begin
         logic [63:0] ra, rb;
         ra = rand_op(8, 23, 1, 254);
         rb = rand_op(8, 23, 1, 254);
         issue(0, ra, rb, model(ra, rb, 8, 23));
         drain(0);
      end

      for (int i = 0; i < 30; i++) begin
         logic [63:0] ra, rb;
         ra = rand_op(11, 52, 900, 1150);
         rb = rand_op(11, 52, 900, 1150);
         issue(1, ra, rb, model(ra, rb, 11, 52));
         drain(1);
      end

      repeat (60) @(negedge clk);
      check("sp_queue_empty", 64'(q_sp.size()), 64'd0);
      check("dp_queue_empty", 64'(q_dp.size()), 64'd0);
      check("final_idle", 64'({busy_s, busy_d}), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
